// File: rtl/bandit_environment.sv
// Bandit environment: accepts an arm index, draws an LFSR sample against a per-arm
// hit probability and returns a signed reward. Optional counters: BANDIT_ENVIRONMENT_STATS_EN.
module bandit_environment #(
    parameter int                 NUM_ARMS    = 256,
    parameter logic [15:0]        SEED        = 16'hACE1,
    parameter logic signed [7:0]  REWARD_HIT  = 8'sd64,
    parameter logic signed [7:0]  REWARD_MISS = -8'sd64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        action_valid,
    input  logic [7:0]  action_data,
    output logic        action_ready,
    output logic        reward_valid,
    output logic [7:0]  reward_data,
    input  logic        reward_ready,
    input  logic        prob_write,
    input  logic [7:0]  prob_index,
    input  logic [7:0]  prob_data,
    output logic [31:0] action_count,
    output logic [31:0] hit_count
);

    localparam int          AW       = (NUM_ARMS > 1) ? $clog2(NUM_ARMS) : 1;
    localparam int          DEPTH    = 1 << AW;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [8:0]  ARMS     = 9'(NUM_ARMS);
    localparam logic [8:0]  LAST     = 9'(NUM_ARMS - 1);

    typedef enum logic [1:0] {INIT, IDLE, DRAW, HOLD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    init_idx;
    logic [7:0]    arm;
    logic [15:0]   lfsr, lfsr_nxt;
    logic [7:0]    prob_table [DEPTH];
    logic [7:0]    prob_rd;
    logic          arm_ok, hit, handshake, init_done;
    logic          tbl_we;
    logic [AW-1:0] tbl_waddr;
    logic [7:0]    tbl_wdata;

    assign handshake = action_valid && action_ready;
    assign init_done = ({1'b0, init_idx} == LAST);

    // Read is combinational on the pre-edge table, so a same-cycle write in DRAW
    // lands after the draw has used the old probability.
    assign arm_ok   = ({1'b0, arm} < ARMS);
    assign prob_rd  = prob_table[arm[AW-1:0]];
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign hit      = arm_ok && (lfsr_nxt[7:0] < prob_rd);

    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = prob_index[AW-1:0];
        tbl_wdata = prob_data;
        if (state == INIT) begin
            tbl_we    = 1'b1;
            tbl_waddr = init_idx[AW-1:0];
            tbl_wdata = 8'h00;
        end else if (prob_write && ({1'b0, prob_index} < ARMS)) begin
            tbl_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (tbl_we) prob_table[tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_done) state_nxt = IDLE;
            IDLE:    if (handshake) state_nxt = DRAW;
            DRAW:    state_nxt = HOLD;
            HOLD:    if (reward_ready) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        action_ready = (state == IDLE);
        reward_valid = (state == HOLD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            init_idx    <= 8'h00;
            arm         <= 8'h00;
            lfsr        <= SEED_EFF;
            reward_data <= 8'h00;
        end else begin
            if (state == INIT && !init_done) init_idx <= init_idx + 8'h01;
            if (handshake) arm <= action_data;
            if (state == DRAW) begin
                lfsr        <= lfsr_nxt;
                reward_data <= hit ? REWARD_HIT : REWARD_MISS;
            end
        end
    end

`ifdef BANDIT_ENVIRONMENT_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            action_count <= 32'h0;
            hit_count    <= 32'h0;
        end else begin
            if (handshake)            action_count <= action_count + 32'h1;
            if (state == DRAW && hit) hit_count    <= hit_count + 32'h1;
        end
    end
`else
    assign action_count = 32'h0;
    assign hit_count    = 32'h0;
`endif

endmodule

// File: tb/tb_bandit_environment.sv
// Bench for bandit_environment: a 256-arm and a 4-arm instance driven from vector
// tables and hand sequences, rewards checked against a model through scoreboards.
module tb_bandit_environment;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset        [2];
    logic        action_valid [2];
    logic [7:0]  action_data  [2];
    logic        action_ready [2];
    logic        reward_valid [2];
    logic [7:0]  reward_data  [2];
    logic        reward_ready [2];
    logic        prob_write   [2];
    logic [7:0]  prob_index   [2];
    logic [7:0]  prob_data    [2];
    logic [31:0] action_count [2];
    logic [31:0] hit_count    [2];

    bandit_environment #(.NUM_ARMS(256)) u_big (
        .clock(clock), .reset(reset[0]),
        .action_valid(action_valid[0]), .action_data(action_data[0]), .action_ready(action_ready[0]),
        .reward_valid(reward_valid[0]), .reward_data(reward_data[0]), .reward_ready(reward_ready[0]),
        .prob_write(prob_write[0]), .prob_index(prob_index[0]), .prob_data(prob_data[0]),
        .action_count(action_count[0]), .hit_count(hit_count[0])
    );

    bandit_environment #(.NUM_ARMS(4)) u_small (
        .clock(clock), .reset(reset[1]),
        .action_valid(action_valid[1]), .action_data(action_data[1]), .action_ready(action_ready[1]),
        .reward_valid(reward_valid[1]), .reward_data(reward_data[1]), .reward_ready(reward_ready[1]),
        .prob_write(prob_write[1]), .prob_index(prob_index[1]), .prob_data(prob_data[1]),
        .action_count(action_count[1]), .hit_count(hit_count[1])
    );

    int          errors = 0;
    int          checks = 0;
    int          num_arms [2] = '{256, 4};
    logic [15:0] lfsr_m  [2];
    logic [7:0]  tab_m   [2][256];
    logic [31:0] act_m   [2];
    logic [31:0] hit_m   [2];
    logic [7:0]  sb0 [$];
    logic [7:0]  sb1 [$];

    localparam int MODEL = 999;

    typedef struct {
        int         d;
        bit         wr;
        logic [7:0] widx;
        logic [7:0] wprob;
        logic [7:0] arm;
        int         hold;
        int         exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk_stats(input int d, input string name);
`ifdef BANDIT_ENVIRONMENT_STATS_EN
        chk({name, "_act"}, action_count[d], act_m[d]);
        chk({name, "_hit"}, hit_count[d], hit_m[d]);
`else
        chk({name, "_act"}, action_count[d], 32'h0);
        chk({name, "_hit"}, hit_count[d], 32'h0);
`endif
    endtask

    task automatic do_reset(input int d, input bit hold_valid, input bit async_chk);
        int n;
        bit rv_bad;
        lfsr_m[d] = 16'hACE1;
        for (int i = 0; i < 256; i++) tab_m[d][i] = 8'h00;
        act_m[d] = 0;
        hit_m[d] = 0;
        if (d == 0) sb0.delete(); else sb1.delete();
        @(negedge clock);
        reset[d] = 1'b0;
        #1;
        if (async_chk) begin
            chk("async_rst_rvalid", {31'h0, reward_valid[d]}, 32'h0);
            chk_stats(d, "async_rst");
        end
        repeat (2) @(posedge clock);
        #1;
        chk("rst_aready", {31'h0, action_ready[d]}, 32'h0);
        chk("rst_rvalid", {31'h0, reward_valid[d]}, 32'h0);
        chk("rst_rdata", {24'h0, reward_data[d]}, 32'h0);
        chk_stats(d, "rst");
        @(negedge clock);
        reset[d] = 1'b1;
        action_valid[d] = hold_valid;
        action_data[d] = 8'h00;
        n = 0;
        rv_bad = 1'b0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (reward_valid[d]) rv_bad = 1'b1;
        end while (!action_ready[d] && n < 600);
        action_valid[d] = 1'b0;
        chk("init_len", n, num_arms[d]);
        chk("init_rvalid", {31'h0, rv_bad}, 32'h0);
    endtask

    task automatic write_prob(input int d, input logic [7:0] idx, input logic [7:0] val);
        @(negedge clock);
        prob_write[d] = 1'b1;
        prob_index[d] = idx;
        prob_data[d]  = val;
        @(posedge clock);
        #1;
        prob_write[d] = 1'b0;
        if (int'(idx) < num_arms[d]) tab_m[d][idx] = val;
    endtask

    // Drives one action through DRAW; optionally writes the same arm during DRAW.
    task automatic send(input int d, input logic [7:0] arm, input bit dw, input logic [7:0] dp,
                        input int exp_ov);
        int k;
        bit h;
        logic [7:0] e;
        @(negedge clock);
        action_valid[d] = 1'b1;
        action_data[d]  = arm;
        k = 0;
        while (!action_ready[d] && k < 600) begin
            @(negedge clock);
            k++;
        end
        if (!action_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: action_ready stuck at 0, required 1");
        end
        @(posedge clock);
        lfsr_m[d] = step(lfsr_m[d]);
        h = (int'(arm) < num_arms[d]) && (lfsr_m[d][7:0] < tab_m[d][arm]);
        act_m[d] = act_m[d] + 32'h1;
        if (h) hit_m[d] = hit_m[d] + 32'h1;
        e = h ? 8'sd64 : -8'sd64;
        if (exp_ov != MODEL) e = 8'(exp_ov);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        #1;
        action_valid[d] = 1'b0;
        action_data[d]  = 8'hxx;
        chk("draw_aready", {31'h0, action_ready[d]}, 32'h0);
        chk("draw_rvalid", {31'h0, reward_valid[d]}, 32'h0);
        reward_ready[d] = 1'b1;
        if (dw) begin
            prob_write[d] = 1'b1;
            prob_index[d] = arm;
            prob_data[d]  = dp;
        end
        @(posedge clock);
        #1;
        reward_ready[d] = 1'b0;
        if (dw) begin
            prob_write[d] = 1'b0;
            if (int'(arm) < num_arms[d]) tab_m[d][arm] = dp;
        end
        chk("lat_rvalid", {31'h0, reward_valid[d]}, 32'h1);
    endtask

    task automatic receive(input int d, input int hold);
        logic [7:0] e;
        bit bad;
        e = 8'h00;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no queued reward, required one");
        end else if (d == 0) e = sb0.pop_front();
        else e = sb1.pop_front();
        chk("reward", {24'h0, reward_data[d]}, {24'h0, e});
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            if (!reward_valid[d] || reward_data[d] !== e || action_ready[d]) bad = 1'b1;
        end
        if (hold > 0) chk("hold_stable", {31'h0, bad}, 32'h0);
        reward_ready[d] = 1'b1;
        @(posedge clock);
        #1;
        reward_ready[d] = 1'b0;
        chk("post_rvalid", {31'h0, reward_valid[d]}, 32'h0);
        chk("post_aready", {31'h0, action_ready[d]}, 32'h1);
    endtask

    vec_t vecs [11];

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; action_valid[d] = 1'b0; action_data[d] = 8'h00;
            reward_ready[d] = 1'b0; prob_write[d] = 1'b0; prob_index[d] = 8'h00; prob_data[d] = 8'h00;
        end

        vecs[0]  = '{0, 1'b1, 8'd3,   8'd113, 8'd3,   0,  64};
        vecs[1]  = '{0, 1'b0, 8'd0,   8'd0,   8'd3,   2,  MODEL};
        vecs[2]  = '{0, 1'b1, 8'd10,  8'd0,   8'd10,  0,  -64};
        vecs[3]  = '{0, 1'b1, 8'd20,  8'd255, 8'd20,  1,  MODEL};
        vecs[4]  = '{0, 1'b0, 8'd0,   8'd0,   8'd200, 10, -64};
        vecs[5]  = '{0, 1'b1, 8'd255, 8'd128, 8'd255, 0,  MODEL};
        vecs[6]  = '{1, 1'b0, 8'd0,   8'd0,   8'd7,   0,  -64};
        vecs[7]  = '{1, 1'b1, 8'd9,   8'd0,   8'd0,   0,  MODEL};
        vecs[8]  = '{1, 1'b0, 8'd0,   8'd0,   8'd1,   0,  MODEL};
        vecs[9]  = '{1, 1'b0, 8'd0,   8'd0,   8'd2,   0,  MODEL};
        vecs[10] = '{1, 1'b0, 8'd0,   8'd0,   8'd3,   0,  MODEL};

        do_reset(0, 1'b1, 1'b0);
        do_reset(1, 1'b1, 1'b0);
        for (int a = 0; a < 4; a++) write_prob(1, 8'(a), 8'd255);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) write_prob(vecs[i].d, vecs[i].widx, vecs[i].wprob);
            send(vecs[i].d, vecs[i].arm, 1'b0, 8'h00, vecs[i].exp);
            receive(vecs[i].d, vecs[i].hold);
        end

        // Fresh LFSR, prob equal to the first sample's low byte: strict compare misses.
        do_reset(0, 1'b0, 1'b0);
        write_prob(0, 8'd3, 8'd112);
        send(0, 8'd3, 1'b0, 8'h00, -64);
        receive(0, 0);

        // Write during DRAW to the arm being drawn: old value (0) governs this draw.
        write_prob(1, 8'd2, 8'd0);
        send(1, 8'd2, 1'b1, 8'd255, -64);
        receive(1, 0);
        send(1, 8'd2, 1'b0, 8'h00, MODEL);
        receive(1, 0);

        do_reset(1, 1'b0, 1'b0);
        write_prob(1, 8'd0, 8'd255);
        for (int i = 0; i < 100; i++) begin
            send(1, 8'd0, 1'b0, 8'h00, MODEL);
            receive(1, 0);
        end
        chk_stats(1, "stats100");

        // Reset landing in HOLD drops the reward and clears the counters.
        send(1, 8'd0, 1'b0, 8'h00, MODEL);
        do_reset(1, 1'b0, 1'b1);
        send(1, 8'd1, 1'b0, 8'h00, -64);
        receive(1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
